// File: rtl/prio_encoder_rr.sv
// Parametrised priority encoder, fixed or round-robin priority,
// with a single registered output stage and valid/ready handshake.
module prio_encoder_rr #(
   parameter int N = 4,
   parameter int RR_MODE = 0,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] idx,
   output logic [N-1:0] grant,
   output logic         none,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] idx_q, idx_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [N-1:0] grant_q, grant_d;
   logic         none_q, none_d;
   logic         valid_q, valid_d;

   logic [W-1:0] win_idx;
   logic [N-1:0] win_grant;
   logic         hit;
   logic         accept;
   int           pos;

   // Single output register: we can take a new request whenever the
   // current result is absent or leaving this cycle.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Find the winning request in the active priority order.
   always_comb begin
      win_idx = '0;
      hit     = 1'b0;
      pos     = 0;
      if (RR_MODE != 0) begin
         // Walk the wrapped order backwards so the first hit in
         // ptr, ptr+1, ... order is the last one written.
         for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr_q) + k;
            if (pos >= N) pos = pos - N;
            if (req[pos]) begin
               win_idx = W'(pos);
               hit     = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               win_idx = W'(i);
               hit     = 1'b1;
            end
         end
      end
      win_grant = hit ? (N'(1) << win_idx) : '0;
   end

   // Next-state for the output register and round-robin pointer.
   always_comb begin
      idx_d   = idx_q;
      grant_d = grant_q;
      none_d  = none_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (accept) begin
         idx_d   = win_idx;
         grant_d = win_grant;
         none_d  = !hit;
         valid_d = 1'b1;
         if (RR_MODE != 0 && hit) begin
            ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset drops any held result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         grant_q <= '0;
         none_q  <= 1'b0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         grant_q <= grant_d;
         none_q  <= none_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign idx       = idx_q;
   assign grant     = grant_q;
   assign none      = none_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: four instances (N=4/5, fixed/RR)
// checked by a per-instance queue scoreboard plus directed vectors.
module tb_prio_encoder_rr;

   typedef struct {
      logic [2:0] idx;
      logic [7:0] grant;
      logic       none;
   } res_t;

   typedef struct {
      logic [7:0] req;
      int         idx;
      logic [7:0] grant;
      bit         none;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] rq [4];
   logic [3:0] iv;
   logic [3:0] ordy;
   logic [3:0] ir;
   logic [3:0] ov;
   logic [3:0] nn;
   logic [1:0] ix0, ix1;
   logic [2:0] ix2, ix3;
   logic [3:0] g0, g1;
   logic [4:0] g2, g3;

   int   ncmp;
   int   nfail;
   res_t sbq [4][$];
   int   mptr [4];
   int   acc_cnt [4];
   vec_t tv [6];

   prio_encoder_rr #(.N(4), .RR_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .req(rq[0][3:0]), .in_valid(iv[0]),
      .in_ready(ir[0]), .idx(ix0), .grant(g0), .none(nn[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]));

   prio_encoder_rr #(.N(4), .RR_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .req(rq[1][3:0]), .in_valid(iv[1]),
      .in_ready(ir[1]), .idx(ix1), .grant(g1), .none(nn[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]));

   prio_encoder_rr #(.N(5), .RR_MODE(1)) dut2 (
      .clk(clk), .rst(rst), .req(rq[2][4:0]), .in_valid(iv[2]),
      .in_ready(ir[2]), .idx(ix2), .grant(g2), .none(nn[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]));

   prio_encoder_rr #(.N(5), .RR_MODE(0)) dut3 (
      .clk(clk), .rst(rst), .req(rq[3][4:0]), .in_valid(iv[3]),
      .in_ready(ir[3]), .idx(ix3), .grant(g3), .none(nn[3]),
      .out_valid(ov[3]), .out_ready(ordy[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   function automatic res_t enc(input int n, input bit rr,
                                input int ptr, input logic [7:0] r);
      res_t o;
      int   p;
      o.idx   = '0;
      o.grant = '0;
      o.none  = (r == 8'd0);
      if (!o.none) begin
         if (!rr) begin
            for (int i = 0; i < n; i++)
               if (r[i]) o.idx = 3'(i);
         end else begin
            for (int j = n - 1; j >= 0; j--) begin
               p = (ptr + j) % n;
               if (r[p]) o.idx = 3'(p);
            end
         end
         o.grant = 8'd1 << o.idx;
      end
      return o;
   endfunction

   function automatic int n_of(input int k);
      return (k < 2) ? 4 : 5;
   endfunction

   function automatic bit rr_of(input int k);
      return (k == 1 || k == 2);
   endfunction

   function automatic int get_idx(input int k);
      case (k)
         0: return int'(ix0);
         1: return int'(ix1);
         2: return int'(ix2);
         default: return int'(ix3);
      endcase
   endfunction

   function automatic int get_grant(input int k);
      case (k)
         0: return int'(g0);
         1: return int'(g1);
         2: return int'(g2);
         default: return int'(g3);
      endcase
   endfunction

   // Scoreboard monitor: compare held result, then predict next edge.
   task automatic mon(input int k);
      res_t e;
      bit   ev;
      string s;
      s = $sformatf("d%0d", k);
      if (rst) begin
         chk({s, "_rst_valid"}, int'(ov[k]), 0);
         chk({s, "_rst_idx"}, get_idx(k), 0);
         chk({s, "_rst_grant"}, get_grant(k), 0);
         chk({s, "_rst_none"}, int'(nn[k]), 0);
         sbq[k].delete();
         mptr[k] = 0;
         return;
      end
      ev = (sbq[k].size() != 0);
      chk({s, "_out_valid"}, int'(ov[k]), int'(ev));
      chk({s, "_in_ready"}, int'(ir[k]), int'(!ev || ordy[k]));
      if (ev) begin
         e = sbq[k][0];
         chk({s, "_idx"}, get_idx(k), int'(e.idx));
         chk({s, "_grant"}, get_grant(k), int'(e.grant));
         chk({s, "_none"}, int'(nn[k]), int'(e.none));
         if (ordy[k]) void'(sbq[k].pop_front());
      end
      if (iv[k] && (!ev || ordy[k])) begin
         e = enc(n_of(k), rr_of(k), mptr[k], rq[k]);
         sbq[k].push_back(e);
         acc_cnt[k]++;
         if (rr_of(k) && !e.none)
            mptr[k] = (int'(e.idx) + 1) % n_of(k);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) mon(k);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One accepted transfer on instance k, checked against constants.
   task automatic xfer(input int k, input logic [7:0] r,
                       input int eidx, input bit enone);
      string s;
      s = $sformatf("d%0d_xfer_%0h", k, r);
      rq[k]   = r;
      iv[k]   = 1'b1;
      ordy[k] = 1'b1;
      step();
      iv[k] = 1'b0;
      chk({s, "_valid"}, int'(ov[k]), 1);
      chk({s, "_idx"}, get_idx(k), eidx);
      chk({s, "_none"}, int'(nn[k]), int'(enone));
      chk({s, "_grant"}, get_grant(k), enone ? 0 : (1 << eidx));
   endtask

   initial begin
      int cyc;
      ncmp  = 0;
      nfail = 0;
      for (int k = 0; k < 4; k++) begin
         mptr[k]    = 0;
         acc_cnt[k] = 0;
      end
      tv[0] = '{8'b1000, 3, 8'b1000, 1'b0};
      tv[1] = '{8'b0100, 2, 8'b0100, 1'b0};
      tv[2] = '{8'b0010, 1, 8'b0010, 1'b0};
      tv[3] = '{8'b0001, 0, 8'b0001, 1'b0};
      tv[4] = '{8'b1011, 3, 8'b1000, 1'b0};
      tv[5] = '{8'b0000, 0, 8'b0000, 1'b1};

      // Reset with requests pending everywhere.
      rst  = 1'b1;
      iv   = 4'hf;
      ordy = 4'hf;
      rq[0] = 8'h0f;
      rq[1] = 8'h0f;
      rq[2] = 8'h1f;
      rq[3] = 8'h1f;
      step();
      step();
      chk("reset_valid", int'(ov[0]), 0);
      chk("reset_idx", int'(ix0), 0);
      chk("reset_grant", int'(g0), 0);
      chk("reset_none", int'(nn[0]), 0);
      rst = 1'b0;
      iv  = 4'h0;
      #1;
      chk("reset_in_ready", int'(ir[0]), 1);

      // Fixed priority vectors, back-to-back at full throughput.
      rq[0]   = 8'h0;
      ordy[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rq[0] = tv[i].req;
         iv[0] = 1'b1;
         step();
         chk($sformatf("tbl%0d_valid", i), int'(ov[0]), 1);
         chk($sformatf("tbl%0d_idx", i), int'(ix0), tv[i].idx);
         chk($sformatf("tbl%0d_grant", i), int'(g0), int'(tv[i].grant));
         chk($sformatf("tbl%0d_none", i), int'(nn[0]), int'(tv[i].none));
      end

      // Zero result held through a 3-cycle stall.
      rq[0]   = 8'b0100;
      iv[0]   = 1'b1;
      ordy[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", int'(ir[0]), 0);
         step();
         chk("stall_none", int'(nn[0]), 1);
         chk("stall_valid", int'(ov[0]), 1);
      end
      xfer(0, 8'b0100, 2, 1'b0);
      step();

      // Round-robin rotation and wrap.
      xfer(1, 8'b1111, 0, 1'b0);
      xfer(1, 8'b1111, 1, 1'b0);
      xfer(1, 8'b1111, 2, 1'b0);
      xfer(1, 8'b1111, 3, 1'b0);
      xfer(1, 8'b1111, 0, 1'b0);
      xfer(1, 8'b0101, 2, 1'b0);

      // Stall with held result must not move the pointer (ptr=3).
      rq[1]   = 8'b1111;
      iv[1]   = 1'b1;
      ordy[1] = 1'b0;
      step();
      step();
      chk("rr_stall_idx", int'(ix1), 2);
      chk("rr_stall_in_ready", int'(ir[1]), 0);
      xfer(1, 8'b1111, 3, 1'b0);
      xfer(1, 8'b0010, 1, 1'b0);
      xfer(1, 8'b0000, 0, 1'b1);
      xfer(1, 8'b1111, 2, 1'b0);
      step();

      // Non-power-of-two width.
      xfer(2, 8'b10000, 4, 1'b0);
      xfer(3, 8'b10000, 4, 1'b0);
      xfer(3, 8'b01011, 3, 1'b0);
      xfer(2, 8'b10001, 0, 1'b0);
      step();

      // Random traffic with random back-pressure on all instances.
      cyc = 0;
      while ((acc_cnt[0] < 500 || acc_cnt[1] < 500 ||
              acc_cnt[2] < 500 || acc_cnt[3] < 500) && cyc < 20000) begin
         for (int k = 0; k < 4; k++) begin
            iv[k]   = ($urandom_range(0, 3) != 0);
            ordy[k] = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) rq[k] = 8'h0;
            else rq[k] = 8'($urandom) & ((k < 2) ? 8'h0f : 8'h1f);
         end
         step();
         cyc++;
      end
      if (cyc >= 20000) chk("random_budget", cyc, 0);
      iv   = 4'h0;
      ordy = 4'hf;
      step();
      step();
      step();
      for (int k = 0; k < 4; k++)
         chk($sformatf("d%0d_drained", k), int'(ov[k]), 0);

      // Asynchronous reset discards a held result mid-cycle.
      rq[0]   = 8'b1000;
      iv[0]   = 1'b1;
      ordy[0] = 1'b0;
      step();
      iv[0] = 1'b0;
      chk("pre_rst_valid", int'(ov[0]), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(ov[0]), 0);
      chk("async_rst_idx", int'(ix0), 0);
      step();
      rst     = 1'b0;
      ordy[0] = 1'b1;
      step();
      chk("post_rst_valid", int'(ov[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised N-to-log2(N) priority encoder with a registered output stage and valid/ready handshake.
- Generalises the fixed 4-to-2 encoder in three ways: any width, a "no request" flag, and an optional round-robin priority mode.
- Sits between request sources (interrupt lines, arbitration requests) and a downstream consumer that may stall.

Parameters:
- N, 4, number of request lines; N >= 2.
- W, $clog2(N), index width; derived, not overridden.
- RR_MODE, 0, 0 = fixed priority (highest index wins); 1 = round-robin priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  N  request vector, sampled on accept.
- in_valid  input  1  req is valid this cycle.
- in_ready  output  1  block can accept req this cycle.
- idx  output  W  encoded index of winning request.
- grant  output  N  one-hot of winning request; all zero when none.
- none  output  1  accepted req was all-zero.
- out_valid  output  1  idx/grant/none hold a result.
- out_ready  input  1  consumer takes the result this cycle.

Behaviour:
- Reset (async, active-high):
  - idx=0, grant=0, none=0, out_valid=0.
  - RR pointer ptr=0.
  - in_ready=1 once reset deasserts.
  - Reset asserted mid-transfer discards any held result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single output register, no skid buffer).
  - Accept: in_valid && in_ready at a rising edge.
  - On accept, the encode result of req is registered. out_valid=1 in the next cycle (latency 1).
- Output register:
  - Holds its value while out_valid && !out_ready; req changes are ignored while stalled.
  - out_valid clears after out_ready && out_valid with no new accept in the same cycle.
  - Simultaneous drain and accept: the new result replaces the old; out_valid stays 1 (full throughput, one result per cycle).
- Fixed mode (RR_MODE=0):
  - Winner is the highest set index of req.
- Round-robin mode (RR_MODE=1):
  - Search order starts at ptr and runs upward with wrap: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - The first set bit in that order wins.
  - After accepting a nonzero req, ptr <= (winner+1) mod N; wrap from N-1 goes to 0.
  - ptr updates only on accept; it does not move on a stall or on an all-zero accept.
- Zero request:
  - Accepting req=0 registers none=1, idx=0, grant=0, out_valid=1.
  - This result is delivered normally and must not be dropped.
- Output invariants:
  - grant is exactly one-hot when none=0, and grant[idx]=1.
  - N not a power of two: idx never exceeds N-1.
- in_valid=0 for any number of cycles: no state changes except output drain.
- Outputs are glitch-free registers; only in_ready is combinational.

Test Plan:
- Reset: hold rst=1 for 2 cycles while req=4'b1111 and in_valid=1 -> out_valid=0, idx=0, grant=0, none=0; in_ready=1 after release.
- Fixed priority, N=4, out_ready=1: apply req 1000, 0100, 0010, 0001, 1011, one per cycle -> idx 3, 2, 1, 0, 3 one cycle later each; grant matches; none=0 throughout.
- Zero and stall: accept req=0 -> none=1, idx=0. Then out_ready=0 for 3 cycles while req=0100 and in_valid=1 -> in_ready=0, outputs frozen at none=1. Raise out_ready -> next result idx=2.
- Round-robin, N=4, RR_MODE=1: accept req=1111 four times -> idx 0, 1, 2, 3, then 0 again (wrap). Accept req=0101 with ptr=1 -> idx=2, ptr becomes 3.
- Round-robin with stall: stall for 2 cycles with a held result -> ptr unchanged. Accept req=0 -> ptr unchanged.
- Non-power-of-two, N=5, W=3: req=5'b10000 -> idx=4. Random 500 accepts with random out_ready -> every result matches the reference model, no result lost or duplicated.
